mem_bus_master: RTL and testbench
=================================

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter: RD_LATENCY, default 1, memory read latency in edges from address-sample edge to data-valid (legal 1..3).
REQ-002 clk  in  1  single clock; all state on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  master can accept; transfer on req_valid && req_ready at posedge.
REQ-006 req_write  in  1  1=write, 0=read.
REQ-007 req_word  in  1  1=16-bit little-endian (two bytes), 0=single byte.
REQ-008 req_pagewrap  in  1  1=high byte address wraps within page (6502 indirect-JMP behaviour).
REQ-009 req_addr  in  16 (addr_t)  low-byte address.
REQ-010 req_wdata  in  16  write data; [7:0] to addr, [15:8] to high address.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  16  read data; [15:8]=0 for byte reads.
REQ-013 mem_mw  out  1  memory write enable.
REQ-014 mem_addr  out  16 (addr_t)  memory address.
REQ-015 mem_wdata  out  8 (data_t)  memory write data.
REQ-016 mem_rdata  in  8 (data_t)  registered memory read data.

Function
REQ-017 All outputs SHALL be registered; FSM states IDLE, ISSUE_LO, ISSUE_HI, WAIT, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; req_* SHALL be ignored otherwise.
REQ-019 Edge E0 = acceptance edge; low-byte access SHALL be driven on mem_* in the cycle after E0.
REQ-020 Word access SHALL issue high-byte access in the cycle immediately after the low-byte access (back-to-back, no bubble).
REQ-021 High address: req_pagewrap=0 -> (A+1) mod 2^16 (0xFFFF->0x0000); req_pagewrap=1 -> {A[15:8], A[7:0]+1 mod 256}.
REQ-022 Read capture: mem_rdata for an access presented in cycle Ck SHALL be sampled at edge E(k-1)+RD_LATENCY+1... i.e. RD_LATENCY edges after memory sample edge.
REQ-023 Latency (RD_LATENCY=1): byte read rsp_valid in cycle after E0+2 edges; word read E0+3; byte write E0+1; word write E0+2.
REQ-024 mem_mw SHALL be 1 only in write-access cycles; 0 in all read, wait, idle cycles.
REQ-025 mem_addr and mem_wdata SHALL hold last value when idle.
REQ-026 rsp_valid SHALL be exactly one cycle; FSM SHALL be IDLE in that cycle, so a new request can be accepted at the edge ending it.
REQ-027 rsp_rdata SHALL hold until the next read completion; writes SHALL NOT modify it.
REQ-028 A read issued after a write to the same address SHALL return the written value (no forwarding needed; memory ordering suffices).

Reset
REQ-029 On rst_n=0 (async): state IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, mem_mw=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset mid-operation SHALL abort the transfer; no rsp_valid SHALL follow; mem_mw SHALL drop immediately.

Structure
REQ-031 Package mem_bus_pkg SHALL hold addr_t (16b), data_t (8b), word_t (16b), the FSM state enum.
REQ-032 One sub-module, rd_tag_pipe: RD_LATENCY-deep shift register tagging in-flight reads (valid, lo/hi) to steer capture.

Verification
REQ-033 Preload mem[0x1234]=0xAB; byte read 0x1234 -> rsp_rdata=0x00AB, rsp_valid 2 edges after E0.
REQ-034 Word write 0x5678 to 0x0200, then word read 0x0200 -> mem[0x200]=0x78, mem[0x201]=0x56, rsp_rdata=0x5678.
REQ-035 mem[0xFFFF]=0x11, mem[0x0000]=0x22; word read 0xFFFF, pagewrap=0 -> 0x2211.
REQ-036 mem[0x30FF]=0x34, mem[0x3000]=0x12, mem[0x3100]=0x99; word read 0x30FF, pagewrap=1 -> 0x1234.
REQ-037 req_valid held high with 4 queued requests -> each accepted in rsp cycle of previous; no lost or duplicate rsp_valid.
REQ-038 Assert rst_n=0 during ISSUE_HI of word write -> mem_mw=0 immediately, no rsp_valid, high byte unwritten.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types for the byte-wide memory bus master.
//   addr_t   16-bit memory address
//   data_t   8-bit memory data byte
//   word_t   16-bit little-endian request/response word
//   state_e  master FSM states
//   rd_tag_t tag carried alongside an in-flight memory read
//   next_hi_addr() address of the high byte of a word access
package mem_bus_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_LO = 3'd1,
    ISSUE_HI = 3'd2,
    WAIT     = 3'd3,
    RESP     = 3'd4
  } state_e;

  // valid: a read is in flight; hi: it is the high byte of a word;
  // last: its capture completes the request.
  typedef struct packed {
    logic valid;
    logic hi;
    logic last;
  } rd_tag_t;

  // Page-wrap mode keeps the page and wraps only the low address byte,
  // mirroring the 6502 indirect-JMP quirk.
  function automatic addr_t next_hi_addr(input addr_t a, input logic pagewrap);
    addr_t r;
    if (pagewrap) begin
      r = {a[15:8], a[7:0] + 8'd1};
    end else begin
      r = a + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-deep shift register that follows each memory read from
// the edge at which memory samples its address to the edge at which the
// master must capture mem_rdata.
//   clk, rst_n  clock, asynchronous active-low reset
//   tag_in      tag of the access presented on the bus this cycle
//   tag_out     tag whose data is on mem_rdata this cycle
module rd_tag_pipe
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [DEPTH-1:0] stage_q;
  rd_tag_t [DEPTH-1:0] stage_d;

  // Shift: stage 0 loads at the memory sample edge, the last stage feeds capture.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset discards every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: turns byte/word read/write requests into byte accesses on a
// synchronous memory with registered read data (RD_LATENCY edges).
//   req_valid/req_ready        request handshake, transfer at posedge
//   req_write/word/pagewrap    request kind and high-address mode
//   req_addr/req_wdata         low-byte address, little-endian write data
//   rsp_valid/rsp_rdata        one-cycle completion pulse, held read data
//   mem_mw/mem_addr/mem_wdata  memory write enable, address, write byte
//   mem_rdata                  registered memory read byte
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  req_valid,
  output logic  req_ready,
  input  logic  req_write,
  input  logic  req_word,
  input  logic  req_pagewrap,
  input  addr_t req_addr,
  input  word_t req_wdata,
  output logic  rsp_valid,
  output word_t rsp_rdata,
  output logic  mem_mw,
  output addr_t mem_addr,
  output data_t mem_wdata,
  input  data_t mem_rdata
);

  state_e  state_q, state_d;
  logic    req_ready_q, req_ready_d;
  logic    rsp_valid_q, rsp_valid_d;
  word_t   rsp_rdata_q, rsp_rdata_d;
  logic    mem_mw_q, mem_mw_d;
  addr_t   mem_addr_q, mem_addr_d;
  data_t   mem_wdata_q, mem_wdata_d;
  logic    write_q, write_d;
  logic    word_q, word_d;
  addr_t   hi_addr_q, hi_addr_d;
  data_t   wdata_hi_q, wdata_hi_d;
  data_t   lo_byte_q, lo_byte_d;
  rd_tag_t tag_in, tag_out;

  rd_tag_pipe #(.DEPTH(RD_LATENCY)) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Tag each read access as it is presented so its data can be steered later.
  always_comb begin
    tag_in = '0;
    if ((state_q == ISSUE_LO || state_q == ISSUE_HI) && !write_q) begin
      tag_in.valid = 1'b1;
      tag_in.hi    = (state_q == ISSUE_HI);
      tag_in.last  = (state_q == ISSUE_HI) || !word_q;
    end else begin
      tag_in = '0;
    end
  end

  // Next-state, bus drive and read-data capture.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    lo_byte_d   = lo_byte_q;
    mem_mw_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    write_d     = write_q;
    word_d      = word_q;
    hi_addr_d   = hi_addr_q;
    wdata_hi_d  = wdata_hi_q;

    // The low byte of a word is parked until its high byte arrives, so
    // rsp_rdata only changes when a read completes.
    if (tag_out.valid) begin
      if (tag_out.hi) begin
        rsp_rdata_d = {mem_rdata, lo_byte_q};
      end else if (tag_out.last) begin
        rsp_rdata_d = {8'h00, mem_rdata};
      end else begin
        lo_byte_d = mem_rdata;
      end
    end else begin
      lo_byte_d = lo_byte_q;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = ISSUE_LO;
          write_d     = req_write;
          word_d      = req_word;
          hi_addr_d   = next_hi_addr(req_addr, req_pagewrap);
          wdata_hi_d  = req_wdata[15:8];
          mem_mw_d    = req_write;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata[7:0];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE_LO: begin
        // High byte follows immediately, no bubble.
        if (word_q) begin
          state_d     = ISSUE_HI;
          mem_mw_d    = write_q;
          mem_addr_d  = hi_addr_q;
          mem_wdata_d = wdata_hi_q;
        end else if (write_q) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      ISSUE_HI: begin
        if (write_q) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Return to IDLE at the completing capture so the response cycle
        // can already accept the next request.
        if (tag_out.valid && tag_out.last) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        // Responses are issued on the way into IDLE; RESP only recovers.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any transfer in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      lo_byte_q   <= 8'h00;
      mem_mw_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      write_q     <= 1'b0;
      word_q      <= 1'b0;
      hi_addr_q   <= 16'h0000;
      wdata_hi_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      lo_byte_q   <= lo_byte_d;
      mem_mw_q    <= mem_mw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      write_q     <= write_d;
      word_q      <= word_d;
      hi_addr_q   <= hi_addr_d;
      wdata_hi_q  <= wdata_hi_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_mw    = mem_mw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed bench for mem_bus_master (RD_LATENCY = 1) with a
// 64 KiB behavioural memory whose read data is registered one edge.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  req_valid = 1'b0;
  logic  req_ready;
  logic  req_write = 1'b0;
  logic  req_word = 1'b0;
  logic  req_pagewrap = 1'b0;
  addr_t req_addr = 16'h0000;
  word_t req_wdata = 16'h0000;
  logic  rsp_valid;
  word_t rsp_rdata;
  logic  mem_mw;
  addr_t mem_addr;
  data_t mem_wdata;
  data_t mem_rdata;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  logic [7:0]  mem [0:65535];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = 16'h0000;
  logic [7:0]  bd_data = 8'h00;

  mem_bus_master #(.RD_LATENCY(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_word     (req_word),
    .req_pagewrap (req_pagewrap),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_mw       (mem_mw),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_mw) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Present one request while idle; returns just after the acceptance edge.
  task automatic issue(input logic w, input logic wd, input logic pw,
                       input logic [15:0] a, input logic [15:0] d, output int e0);
    req_write = w; req_word = wd; req_pagewrap = pw; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    e0 = cyc;
  endtask

  // Edges from acceptance to the response cycle, or -1 on timeout.
  task automatic wait_rsp(input int e0, output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        lat = cyc - e0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic load_req(input int i);
    case (i)
      0: begin req_write = 1'b0; req_word = 1'b0; req_addr = 16'h1234; req_wdata = 16'h0000; end
      1: begin req_write = 1'b1; req_word = 1'b0; req_addr = 16'h1234; req_wdata = 16'h005C; end
      2: begin req_write = 1'b0; req_word = 1'b0; req_addr = 16'h1234; req_wdata = 16'h0000; end
      default: begin req_write = 1'b0; req_word = 1'b1; req_addr = 16'h0200; req_wdata = 16'h0000; end
    endcase
    req_pagewrap = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    nvec++; if (rsp_rdata !== 16'h0000) begin nerr++; $display("FAIL reset_rdata: got %h want 0000", rsp_rdata); end
    nvec++; if (mem_mw !== 1'b0) begin nerr++; $display("FAIL reset_mw: got %b want 0", mem_mw); end
    nvec++; if (mem_addr !== 16'h0000) begin nerr++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
    nvec++; if (mem_wdata !== 8'h00) begin nerr++; $display("FAIL reset_wdata: got %h want 00", mem_wdata); end
  endtask

  task automatic test_byte_read();
    int e0, lat;
    issue(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, e0);
    nvec++; if (mem_addr !== 16'h1234) begin nerr++; $display("FAIL br_addr: got %h want 1234", mem_addr); end
    nvec++; if (mem_mw !== 1'b0) begin nerr++; $display("FAIL br_mw: got %b want 0", mem_mw); end
    nvec++; if (req_ready !== 1'b0) begin nerr++; $display("FAIL br_busy_ready: got %b want 0", req_ready); end
    wait_rsp(e0, lat);
    nvec++; if (lat !== 2) begin nerr++; $display("FAIL br_latency: got %0d want 2", lat); end
    nvec++; if (rsp_rdata !== 16'h00AB) begin nerr++; $display("FAIL br_rdata: got %h want 00ab", rsp_rdata); end
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL br_rsp_ready: got %b want 1", req_ready); end
    @(posedge clk); #1;
    nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL br_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_word_write_read();
    int e0, lat;
    issue(1'b1, 1'b1, 1'b0, 16'h0200, 16'h5678, e0);
    nvec++; if ({mem_mw, mem_addr, mem_wdata} !== {1'b1, 16'h0200, 8'h78}) begin
      nerr++; $display("FAIL ww_lo: got %b/%h/%h want 1/0200/78", mem_mw, mem_addr, mem_wdata); end
    @(posedge clk); #1;
    nvec++; if ({mem_mw, mem_addr, mem_wdata} !== {1'b1, 16'h0201, 8'h56}) begin
      nerr++; $display("FAIL ww_hi: got %b/%h/%h want 1/0201/56", mem_mw, mem_addr, mem_wdata); end
    wait_rsp(e0, lat);
    nvec++; if (lat !== 2) begin nerr++; $display("FAIL ww_latency: got %0d want 2", lat); end
    nvec++; if (mem[16'h0200] !== 8'h78) begin nerr++; $display("FAIL ww_mem200: got %h want 78", mem[16'h0200]); end
    nvec++; if (mem[16'h0201] !== 8'h56) begin nerr++; $display("FAIL ww_mem201: got %h want 56", mem[16'h0201]); end
    nvec++; if (rsp_rdata !== 16'h00AB) begin nerr++; $display("FAIL ww_rdata_hold: got %h want 00ab", rsp_rdata); end
    nvec++; if (mem_mw !== 1'b0) begin nerr++; $display("FAIL ww_mw_drop: got %b want 0", mem_mw); end
    issue(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, e0);
    wait_rsp(e0, lat);
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL wr_latency: got %0d want 3", lat); end
    nvec++; if (rsp_rdata !== 16'h5678) begin nerr++; $display("FAIL wr_rdata: got %h want 5678", rsp_rdata); end
  endtask

  task automatic test_wrap();
    int e0, lat;
    issue(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, e0);
    nvec++; if (mem_addr !== 16'hFFFF) begin nerr++; $display("FAIL wrap0_lo: got %h want ffff", mem_addr); end
    @(posedge clk); #1;
    nvec++; if (mem_addr !== 16'h0000) begin nerr++; $display("FAIL wrap0_hi: got %h want 0000", mem_addr); end
    nvec++; if (mem_mw !== 1'b0) begin nerr++; $display("FAIL wrap0_mw: got %b want 0", mem_mw); end
    wait_rsp(e0, lat);
    nvec++; if (lat !== 3) begin nerr++; $display("FAIL wrap0_latency: got %0d want 3", lat); end
    nvec++; if (rsp_rdata !== 16'h2211) begin nerr++; $display("FAIL wrap0_rdata: got %h want 2211", rsp_rdata); end
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 1'b1, 16'h30FF, 16'h0000, e0);
    @(posedge clk); #1;
    nvec++; if (mem_addr !== 16'h3000) begin nerr++; $display("FAIL wrap1_hi: got %h want 3000", mem_addr); end
    wait_rsp(e0, lat);
    nvec++; if (rsp_rdata !== 16'h1234) begin nerr++; $display("FAIL wrap1_rdata: got %h want 1234", rsp_rdata); end
    @(posedge clk); #1;
    nvec++; if (mem_addr !== 16'h3000) begin nerr++; $display("FAIL idle_addr_hold: got %h want 3000", mem_addr); end
  endtask

  task automatic test_byte_write();
    int e0, lat;
    poke(16'h4001, 8'h5A);
    issue(1'b1, 1'b0, 1'b0, 16'h4000, 16'h99C3, e0);
    wait_rsp(e0, lat);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL bw_latency: got %0d want 1", lat); end
    nvec++; if (mem[16'h4000] !== 8'hC3) begin nerr++; $display("FAIL bw_mem: got %h want c3", mem[16'h4000]); end
    nvec++; if (rsp_rdata !== 16'h1234) begin nerr++; $display("FAIL bw_rdata_hold: got %h want 1234", rsp_rdata); end
    @(posedge clk); #1;
    nvec++; if (mem[16'h4001] !== 8'h5A) begin nerr++; $display("FAIL bw_no_hi: got %h want 5a", mem[16'h4001]); end
    nvec++; if ({mem_mw, mem_wdata} !== {1'b0, 8'hC3}) begin
      nerr++; $display("FAIL bw_idle: got %b/%h want 0/c3", mem_mw, mem_wdata); end
  endtask

  task automatic test_back_to_back();
    int idx, nrsp, extra;
    logic acc;
    word_t exp [4];
    exp[0] = 16'h00AB; exp[1] = 16'h00AB; exp[2] = 16'h005C; exp[3] = 16'h5678;
    idx = 0; nrsp = 0;
    load_req(0);
    req_valid = 1'b1;
    for (int c = 0; c < 60 && nrsp < 4; c++) begin
      if (rsp_valid) begin
        nvec++; if (rsp_rdata !== exp[nrsp]) begin
          nerr++; $display("FAIL b2b_rdata%0d: got %h want %h", nrsp, rsp_rdata, exp[nrsp]); end
        if (idx < 4) begin
          nvec++; if (req_ready !== 1'b1) begin
            nerr++; $display("FAIL b2b_ready_in_rsp%0d: got %b want 1", nrsp, req_ready); end
        end
        nrsp++;
      end
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) load_req(idx);
        else req_valid = 1'b0;
      end
    end
    nvec++; if (nrsp !== 4) begin nerr++; $display("FAIL b2b_rsp_count: got %0d want 4", nrsp); end
    nvec++; if (idx !== 4) begin nerr++; $display("FAIL b2b_accept_count: got %0d want 4", idx); end
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) extra++;
      @(posedge clk); #1;
    end
    nvec++; if (extra !== 0) begin nerr++; $display("FAIL b2b_extra_rsp: got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int e0, nrsp;
    poke(16'h6000, 8'h00);
    poke(16'h6001, 8'hEE);
    issue(1'b1, 1'b1, 1'b0, 16'h6000, 16'hBBAA, e0);
    @(posedge clk); #1;
    nvec++; if ({mem_mw, mem_addr} !== {1'b1, 16'h6001}) begin
      nerr++; $display("FAIL rm_issue_hi: got %b/%h want 1/6001", mem_mw, mem_addr); end
    #1 rst_n = 1'b0;
    #1;
    nvec++; if (mem_mw !== 1'b0) begin nerr++; $display("FAIL rm_mw_drop: got %b want 0", mem_mw); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) nrsp++;
      @(posedge clk); #1;
    end
    nvec++; if (nrsp !== 0) begin nerr++; $display("FAIL rm_no_rsp: got %0d want 0", nrsp); end
    nvec++; if (mem[16'h6001] !== 8'hEE) begin nerr++; $display("FAIL rm_hi_unwritten: got %h want ee", mem[16'h6001]); end
    nvec++; if (mem[16'h6000] !== 8'hAA) begin nerr++; $display("FAIL rm_lo_written: got %h want aa", mem[16'h6000]); end
    nvec++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rm_ready: got %b want 1", req_ready); end
  endtask

  initial begin
    test_reset();
    poke(16'h1234, 8'hAB);
    poke(16'hFFFF, 8'h11);
    poke(16'h0000, 8'h22);
    poke(16'h30FF, 8'h34);
    poke(16'h3000, 8'h12);
    poke(16'h3100, 8'h99);
    test_byte_read();
    test_word_write_read();
    test_wrap();
    test_byte_write();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
